// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave countdown timer.
// Optional build macro: DOOR_INTERLOCK_EN (adds a door_open input to the bus).
package microwave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

  // Prescaler width covers TICKS_PER_SEC up to 127.
  localparam int PRESC_W = 7;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
  } mmss_t;

  // Saturate a loaded digit to the largest legal value for its position.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] d, input logic [3:0] max_val);
    return (d > max_val) ? max_val : d;
  endfunction

endpackage

// File: rtl/microwave_countdown_if.sv
// Control/status bus between the front-panel controller (master) and the
// countdown block (slave). Handshake: there is no valid/ready pair; every
// control input is a one-cycle strobe sampled on the rising clock edge, and
// every status output is a registered level valid one cycle after the strobe.
// Optional build macro: DOOR_INTERLOCK_EN adds the door_open level input.
interface microwave_countdown_if;
  import microwave_pkg::*;

  logic       tick;
  logic       load;
  logic [3:0] load_min_tens;
  logic [3:0] load_min_ones;
  logic [3:0] load_sec_tens;
  logic [3:0] load_sec_ones;
  logic       start;
  logic       pause;
  logic       clear;
`ifdef DOOR_INTERLOCK_EN
  logic       door_open;
`endif
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       done;
  state_e     state_dbg;

  modport master (
    output tick, load, load_min_tens, load_min_ones, load_sec_tens, load_sec_ones,
    output start, pause, clear,
`ifdef DOOR_INTERLOCK_EN
    output door_open,
`endif
    input  min_tens, min_ones, sec_tens, sec_ones, running, done, state_dbg
  );

  modport slave (
    input  tick, load, load_min_tens, load_min_ones, load_sec_tens, load_sec_ones,
    input  start, pause, clear,
`ifdef DOOR_INTERLOCK_EN
    input  door_open,
`endif
    output min_tens, min_ones, sec_tens, sec_ones, running, done, state_dbg
  );

endinterface

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown borrow chain. Purely combinational: given
// the current digit and a decrement enable, produces the next digit and a
// borrow into the next-more-significant digit when wrapping 0 -> MAX_VAL.
module bcd_digit_down
  import microwave_pkg::*;
#(
  parameter logic [3:0] MAX_VAL = BCD_NINE
) (
  input  logic [3:0] i_digit,
  input  logic       i_dec,
  output logic [3:0] o_digit,
  output logic       o_borrow
);

  logic w_zero;
  assign w_zero = (i_digit == 4'd0);

  // Decrement with wrap to the digit's maximum on underflow.
  always_comb begin
    o_digit  = i_digit;
    o_borrow = 1'b0;
    if (i_dec) begin
      o_borrow = w_zero;
      o_digit  = w_zero ? MAX_VAL : (i_digit - 4'd1);
    end
  end

endmodule

// File: rtl/microwave_countdown.sv
// BCD mm:ss countdown timer for a microwave oven. Counts divider ticks into
// seconds and decrements the displayed time, with load/start/pause/clear
// control and a one-cycle done pulse when 00:00 is reached.
// Optional build macro: DOOR_INTERLOCK_EN (door_open forces RUN -> PAUSE).
module microwave_countdown
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 10
) (
  input logic                  clk,
  input logic                  rst,
  microwave_countdown_if.slave bus
);

  state_e             r_state;
  logic [PRESC_W-1:0] r_presc;
  mmss_t              r_time;
  logic               r_running;
  logic               r_done;

  state_e             w_state_nxt;
  logic [PRESC_W-1:0] w_presc_nxt;
  mmss_t              w_time_nxt;
  logic               w_done_nxt;
  mmss_t              w_time_dec;
  mmss_t              w_time_ld;
  logic               w_b_so;
  logic               w_b_st;
  logic               w_b_mo;
  logic               w_b_mt;
  logic               w_sec_wrap;
  logic               w_time_zero;
  logic               w_dec_zero;

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  // Borrow chain: the seconds-ones digit always decrements; each higher
  // digit decrements only when the one below it wraps.
  bcd_digit_down #(.MAX_VAL(BCD_NINE)) u_sec_ones (
    .i_digit(r_time.sec_ones), .i_dec(1'b1),   .o_digit(w_time_dec.sec_ones), .o_borrow(w_b_so)
  );
  bcd_digit_down #(.MAX_VAL(BCD_FIVE)) u_sec_tens (
    .i_digit(r_time.sec_tens), .i_dec(w_b_so), .o_digit(w_time_dec.sec_tens), .o_borrow(w_b_st)
  );
  bcd_digit_down #(.MAX_VAL(BCD_NINE)) u_min_ones (
    .i_digit(r_time.min_ones), .i_dec(w_b_st), .o_digit(w_time_dec.min_ones), .o_borrow(w_b_mo)
  );
  bcd_digit_down #(.MAX_VAL(BCD_NINE)) u_min_tens (
    .i_digit(r_time.min_tens), .i_dec(w_b_mo), .o_digit(w_time_dec.min_tens), .o_borrow(w_b_mt)
  );

  assign w_time_ld.min_tens = bcd_clamp(bus.load_min_tens, BCD_NINE);
  assign w_time_ld.min_ones = bcd_clamp(bus.load_min_ones, BCD_NINE);
  assign w_time_ld.sec_tens = bcd_clamp(bus.load_sec_tens, BCD_FIVE);
  assign w_time_ld.sec_ones = bcd_clamp(bus.load_sec_ones, BCD_NINE);

  assign w_sec_wrap  = (r_presc == PRESC_LAST);
  assign w_time_zero = (r_time == '0);
  // A min_tens borrow would mean underflow below 00:00; never treated as zero.
  assign w_dec_zero  = (w_time_dec == '0) && !w_b_mt;

  // Next-state, prescaler and time selection in control-priority order.
  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_time_nxt  = r_time;
    w_done_nxt  = 1'b0;
    if (bus.clear) begin
      w_state_nxt = IDLE;
      w_presc_nxt = '0;
      w_time_nxt  = '0;
    end
`ifdef DOOR_INTERLOCK_EN
    else if (bus.door_open) begin
      if (r_state == RUN) w_state_nxt = PAUSE;
    end
`endif
    else if (bus.load) begin
      if (r_state != RUN) begin
        w_time_nxt = w_time_ld;
        if (r_state == PAUSE) w_presc_nxt = '0;
      end
    end else if (bus.pause) begin
      if (r_state == RUN) w_state_nxt = PAUSE;
    end else if (bus.start) begin
      if (r_state != RUN && !w_time_zero) begin
        w_state_nxt = RUN;
        if (r_state == IDLE) w_presc_nxt = '0;
      end
    end else if (bus.tick && r_state == RUN) begin
      if (w_sec_wrap) begin
        w_presc_nxt = '0;
        w_time_nxt  = w_time_dec;
        if (w_dec_zero) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end else begin
        w_presc_nxt = r_presc + PRESC_W'(1);
      end
    end
  end

  // State, prescaler, time and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_presc   <= '0;
      r_time    <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_time    <= w_time_nxt;
      r_running <= (w_state_nxt == RUN);
      r_done    <= w_done_nxt;
    end
  end

  assign bus.min_tens  = r_time.min_tens;
  assign bus.min_ones  = r_time.min_ones;
  assign bus.sec_tens  = r_time.sec_tens;
  assign bus.sec_ones  = r_time.sec_ones;
  assign bus.running   = r_running;
  assign bus.done      = r_done;
  assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_microwave_countdown.sv
// Testbench for microwave_countdown: directed scenarios followed by random
// control traffic, checked cycle by cycle against a seconds-based model.
module tb_microwave_countdown;

  localparam int TPS = 10;

  localparam logic [6:0] C_TICK  = 7'h01;
  localparam logic [6:0] C_START = 7'h02;
  localparam logic [6:0] C_PAUSE = 7'h04;
  localparam logic [6:0] C_LOAD  = 7'h08;
  localparam logic [6:0] C_CLEAR = 7'h10;
  localparam logic [6:0] C_RST   = 7'h20;
  localparam logic [6:0] C_DOOR  = 7'h40;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  microwave_countdown_if mif();

  microwave_countdown #(.TICKS_PER_SEC(TPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time held as total seconds.
  int m_secs  = 0;
  int m_presc = 0;
  int m_mode  = M_IDLE;
  logic door_lvl = 1'b0;

  function automatic int clampi(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [17:0] pack_exp(input int secs, input int mode, input logic dn);
    int mm, ss;
    logic [3:0] mt, mo, st, so;
    mm = secs / 60;
    ss = secs % 60;
    mt = 4'(mm / 10);
    mo = 4'(mm % 10);
    st = 4'(ss / 10);
    so = 4'(ss % 10);
    return {mt, mo, st, so, (mode == M_RUN), dn};
  endfunction

  task automatic model_step(input logic [6:0] ctl, input logic [15:0] ld);
    logic dn;
    int mins, secs;
    logic door_act;
    dn = 1'b0;
`ifdef DOOR_INTERLOCK_EN
    door_act = ctl[6];
`else
    door_act = 1'b0;
`endif
    if (ctl[5]) begin
      m_secs = 0; m_presc = 0; m_mode = M_IDLE;
    end else if (ctl[4]) begin
      m_secs = 0; m_presc = 0; m_mode = M_IDLE;
    end else if (door_act) begin
      if (m_mode == M_RUN) m_mode = M_PAUSE;
    end else if (ctl[3]) begin
      if (m_mode != M_RUN) begin
        mins = clampi(int'(ld[15:12]), 9) * 10 + clampi(int'(ld[11:8]), 9);
        secs = clampi(int'(ld[7:4]), 5) * 10 + clampi(int'(ld[3:0]), 9);
        m_secs = mins * 60 + secs;
        if (m_mode == M_PAUSE) m_presc = 0;
      end
    end else if (ctl[2]) begin
      if (m_mode == M_RUN) m_mode = M_PAUSE;
    end else if (ctl[1]) begin
      if (m_mode != M_RUN && m_secs > 0) begin
        if (m_mode == M_IDLE) m_presc = 0;
        m_mode = M_RUN;
      end
    end else if (ctl[0] && m_mode == M_RUN) begin
      m_presc++;
      if (m_presc == TPS) begin
        m_presc = 0;
        m_secs--;
        if (m_secs == 0) begin
          m_mode = M_IDLE;
          dn = 1'b1;
        end
      end
    end
    exp_q.push_back(pack_exp(m_secs, m_mode, dn));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [6:0] ctl, input logic [15:0] ld);
    logic [6:0] c;
    c = ctl | (door_lvl ? C_DOOR : 7'h00);
    @(negedge clk);
    rst               = c[5];
    mif.clear         = c[4];
    mif.load          = c[3];
    mif.pause         = c[2];
    mif.start         = c[1];
    mif.tick          = c[0];
`ifdef DOOR_INTERLOCK_EN
    mif.door_open     = c[6];
`endif
    mif.load_min_tens = ld[15:12];
    mif.load_min_ones = ld[11:8];
    mif.load_sec_tens = ld[7:4];
    mif.load_sec_ones = ld[3:0];
    model_step(c, ld);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(7'h00, 16'h0);
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(C_TICK, 16'h0);
      idle(gap - 1);
    end
  endtask

  task automatic load_time(input logic [15:0] t);
    step(C_LOAD, t);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [17:0] exp_v, act_v;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {mif.min_tens, mif.min_ones, mif.sec_tens, mif.sec_ones, mif.running, mif.done};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL outputs @%0t: got time=%h%h:%h%h run=%b done=%b, want time=%h%h:%h%h run=%b done=%b",
                 $time, act_v[17:14], act_v[13:10], act_v[9:6], act_v[5:2], act_v[1], act_v[0],
                 exp_v[17:14], exp_v[13:10], exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int r;
    logic [6:0] c;
    mif.tick = 0; mif.load = 0; mif.start = 0; mif.pause = 0; mif.clear = 0;
    mif.load_min_tens = 0; mif.load_min_ones = 0; mif.load_sec_tens = 0; mif.load_sec_ones = 0;
`ifdef DOOR_INTERLOCK_EN
    mif.door_open = 0;
`endif
    step(C_RST, 16'h0);
    step(C_RST, 16'h0);
    idle(2);

    // 00:03 counts to zero with a tick every 100 clocks.
    load_time(16'h0003);
    step(C_START, 16'h0);
    ticks(30, 100);
    idle(3);

    // Borrow across the minute and across the tens of minutes.
    load_time(16'h0100);
    step(C_START, 16'h0);
    ticks(10, 2);
    step(C_CLEAR, 16'h0);
    load_time(16'h1000);
    step(C_START, 16'h0);
    ticks(10, 2);
    step(C_CLEAR, 16'h0);

    // Pause keeps the prescaler; ticks while paused are ignored.
    load_time(16'h0005);
    step(C_START, 16'h0);
    ticks(4, 2);
    step(C_PAUSE, 16'h0);
    ticks(20, 2);
    step(C_START, 16'h0);
    ticks(6, 2);
    step(C_CLEAR, 16'h0);

    // Clamping on load, then start with zero time.
    load_time(16'h007C);
    idle(2);
    step(C_CLEAR, 16'h0);
    load_time(16'h0000);
    step(C_START, 16'h0);
    idle(2);
    load_time(16'hFFFF);
    idle(1);

    // Clear together with tick in RUN; load during RUN ignored.
    load_time(16'h0230);
    step(C_START, 16'h0);
    ticks(3, 2);
    step(C_LOAD | C_TICK, 16'h0111);
    step(C_LOAD, 16'h0111);
    ticks(9, 2);
    step(C_CLEAR | C_TICK, 16'h0);
    idle(2);

`ifdef DOOR_INTERLOCK_EN
    // Door opening forces PAUSE; start is ignored until the door closes.
    load_time(16'h0010);
    step(C_START, 16'h0);
    ticks(3, 2);
    door_lvl = 1'b1;
    idle(2);
    step(C_START, 16'h0);
    ticks(5, 2);
    door_lvl = 1'b0;
    step(C_START, 16'h0);
    ticks(10, 2);
    step(C_CLEAR, 16'h0);
`endif

    // Random control traffic.
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 600)      c = C_TICK;
      else if (r < 680) c = C_START;
      else if (r < 710) c = C_PAUSE;
      else if (r < 760) c = C_LOAD;
      else if (r < 770) c = C_CLEAR;
      else if (r < 800) c = C_TICK | 7'(($urandom_range(0, 3)) << 1);
      else if (r < 802) c = C_RST;
      else              c = 7'h00;
`ifdef DOOR_INTERLOCK_EN
      if ($urandom_range(0, 99) < 2) door_lvl = ~door_lvl;
`endif
      step(c, 16'($urandom_range(0, 65535)) & (($urandom_range(0, 3) == 0) ? 16'h00FF : 16'hFFFF));
    end

    door_lvl = 1'b0;
    idle(3);
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
